// File: rtl/seg_scan_decoder.sv
// Receive end of the multiplexed active-low 7-segment display bus. Each digit
// must be seen stable for STABLE_CYCLES samples before it is decoded back into
// a hex nibble; a strobe marks completion of a full multi-digit frame.
module seg_scan_decoder #(
    parameter int unsigned NUM_DIGITS    = 4,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic [6:0]              Seg,
    input  logic [NUM_DIGITS-1:0]   Digit_Sel,
    output logic [4*NUM_DIGITS-1:0] Value,
    output logic [NUM_DIGITS-1:0]   Err,
    output logic [NUM_DIGITS-1:0]   Blank,
    output logic                    Frame_Valid,
    output logic                    Sel_Err
);

    localparam int unsigned CntW  = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned IdxW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned LowW  = $clog2(NUM_DIGITS + 1);

    typedef enum logic [1:0] {StWait, StCount, StHeld} state_t;

    logic [6:0]              seg_s, seg_p;
    logic [NUM_DIGITS-1:0]   sel_s, sel_p;
    state_t                  state_q, state_d;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic [4*NUM_DIGITS-1:0] value_q;
    logic [NUM_DIGITS-1:0]   err_q, blank_q, seen_q;
    logic                    frame_q, sel_err_q;

    logic [LowW-1:0]         low_cnt;
    logic [IdxW-1:0]         sel_idx;
    logic                    sel_valid, sel_multi, same, capture;
    logic [3:0]              dec_nib;
    logic                    dec_err, dec_blank;

    // Input stage: current sample S and previous sample P; reset makes both an idle bus.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            seg_s <= '1;
            sel_s <= '1;
            seg_p <= '1;
            sel_p <= '1;
        end else begin
            seg_s <= Seg;
            sel_s <= Digit_Sel;
            seg_p <= seg_s;
            sel_p <= sel_s;
        end
    end

    // Count active (low) anodes and locate the selected digit.
    always_comb begin
        low_cnt = '0;
        sel_idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!sel_s[i]) begin
                low_cnt = low_cnt + LowW'(1);
                sel_idx = IdxW'(i);
            end
        end
    end

    assign sel_valid = (low_cnt == LowW'(1));
    assign sel_multi = (low_cnt > LowW'(1));
    assign same      = ({seg_s, sel_s} == {seg_p, sel_p});

    // Glyph decode of the current sample.
    always_comb begin
        dec_nib   = 4'h0;
        dec_err   = 1'b0;
        dec_blank = 1'b0;
        case (seg_s)
            7'b1000000: dec_nib = 4'h0;
            7'b1111001: dec_nib = 4'h1;
            7'b0100100: dec_nib = 4'h2;
            7'b0110000: dec_nib = 4'h3;
            7'b0011001: dec_nib = 4'h4;
            7'b0010010: dec_nib = 4'h5;
            7'b0000010: dec_nib = 4'h6;
            7'b1111000: dec_nib = 4'h7;
            7'b0000000: dec_nib = 4'h8;
            7'b0010000: dec_nib = 4'h9;
            7'b0001000: dec_nib = 4'hA;
            7'b0000011: dec_nib = 4'hB;
            7'b1000110: dec_nib = 4'hC;
            7'b0100001: dec_nib = 4'hD;
            7'b0000110: dec_nib = 4'hE;
            7'b0001110: dec_nib = 4'hF;
            7'b1111111: dec_blank = 1'b1;
            default:    dec_err = 1'b1;
        endcase
    end

    // FSM state and stability counter registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= StWait;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: cnt_d counts matching samples including the current one, so a
    // capture fires as soon as the STABLE_CYCLES-th sample is in S.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        unique case (state_q)
            StWait: begin
                cnt_d = '0;
                if (sel_valid) begin
                    state_d = StCount;
                    cnt_d   = CntW'(1);
                end
            end
            StCount: begin
                if (!sel_valid) begin
                    state_d = StWait;
                    cnt_d   = '0;
                end else begin
                    cnt_d = same ? cnt_q + CntW'(1) : CntW'(1);
                    if (cnt_d == CntW'(STABLE_CYCLES)) begin
                        capture = 1'b1;
                        state_d = StHeld;
                    end
                end
            end
            StHeld: begin
                if (!same) begin
                    state_d = sel_valid ? StCount : StWait;
                    cnt_d   = sel_valid ? CntW'(1) : '0;
                end
            end
            default: begin
                state_d = StWait;
                cnt_d   = '0;
            end
        endcase
    end

    // Capture registers, frame tracking and sticky multi-anode flag.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            value_q   <= '0;
            err_q     <= '0;
            blank_q   <= '0;
            seen_q    <= '0;
            frame_q   <= 1'b0;
            sel_err_q <= 1'b0;
        end else begin
            frame_q <= 1'b0;
            if (capture) begin
                value_q[4*sel_idx +: 4] <= dec_nib;
                err_q[sel_idx]          <= dec_err;
                blank_q[sel_idx]        <= dec_blank;
                if ((seen_q | ~sel_s) == '1) begin
                    frame_q <= 1'b1;
                    seen_q  <= '0;
                end else begin
                    seen_q <= seen_q | ~sel_s;
                end
            end
            if (sel_multi) begin
                sel_err_q <= 1'b1;
            end
        end
    end

    assign Value       = value_q;
    assign Err         = err_q;
    assign Blank       = blank_q;
    assign Frame_Valid = frame_q;
    assign Sel_Err     = sel_err_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Randomised and directed bench for seg_scan_decoder with a run-length
// reference model and a frame scoreboard.
module tb_seg_scan_decoder;

    localparam int ND = 4;
    localparam int SC = 4;

    typedef struct packed {
        logic [15:0] v;
        logic [3:0]  e;
        logic [3:0]  b;
    } frame_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  seg = 7'h7f;
    logic [3:0]  sel = 4'hf;
    logic [15:0] value;
    logic [3:0]  err, blank;
    logic        fv, sel_err;

    int total = 0;
    int bad   = 0;

    logic [6:0] glyph [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    // Reference model state: what the outputs should show in the current cycle.
    logic [15:0] m_value  = '0;
    logic [3:0]  m_err    = '0;
    logic [3:0]  m_blank  = '0;
    logic [3:0]  m_seen   = '0;
    logic        m_fv     = 1'b0;
    logic        m_selerr = 1'b0;
    logic [10:0] prev     = '1;
    int          run      = 0;
    logic        p_cap = 1'b0, p_err = 1'b0, p_blank = 1'b0, p_selerr = 1'b0, p_frame = 1'b0;
    int          p_dig = 0;
    logic [3:0]  p_nib = '0;
    frame_t      exp_q [$];
    logic        mon_on = 1'b0;

    seg_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
        .Clk(clk), .Reset(rst), .Seg(seg), .Digit_Sel(sel),
        .Value(value), .Err(err), .Blank(blank), .Frame_Valid(fv), .Sel_Err(sel_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void mdecode(input logic [6:0] s, output logic [3:0] n,
                                    output logic e, output logic b);
        n = 4'h0;
        e = 1'b1;
        b = 1'b0;
        if (s == 7'h7f) begin
            e = 1'b0;
            b = 1'b1;
        end else begin
            for (int k = 0; k < 16; k++) begin
                if (glyph[k] == s) begin
                    n = k[3:0];
                    e = 1'b0;
                end
            end
        end
    endfunction

    // Model: a digit is captured when a run of identical samples with exactly one
    // active anode reaches length SC; the result becomes visible one edge later.
    initial forever begin
        @(posedge clk);
        if (rst) begin
            if (p_cap && p_frame) void'(exp_q.pop_back());
            m_value = '0; m_err = '0; m_blank = '0; m_seen = '0;
            m_fv = 1'b0; m_selerr = 1'b0; prev = '1; run = 0;
            p_cap = 1'b0; p_selerr = 1'b0; p_frame = 1'b0;
        end else begin
            int nlow;
            int idx;
            m_fv = 1'b0;
            if (p_cap) begin
                m_value[p_dig*4 +: 4] = p_nib;
                m_err[p_dig]   = p_err;
                m_blank[p_dig] = p_blank;
                m_seen[p_dig]  = 1'b1;
                if (m_seen == 4'hf) begin
                    m_fv   = 1'b1;
                    m_seen = '0;
                end
            end
            if (p_selerr) m_selerr = 1'b1;
            p_cap = 1'b0; p_selerr = 1'b0; p_frame = 1'b0;
            nlow = 0;
            idx  = 0;
            for (int i = 0; i < ND; i++) if (!sel[i]) begin nlow++; idx = i; end
            if ({seg, sel} == prev) run++;
            else run = 1;
            prev = {seg, sel};
            if (nlow > 1) p_selerr = 1'b1;
            if (nlow == 1 && run == SC) begin
                logic [3:0] nseen;
                frame_t f;
                p_cap = 1'b1;
                p_dig = idx;
                mdecode(seg, p_nib, p_err, p_blank);
                nseen = m_seen;
                nseen[idx] = 1'b1;
                if (nseen == 4'hf) begin
                    f.v = m_value; f.e = m_err; f.b = m_blank;
                    f.v[idx*4 +: 4] = p_nib;
                    f.e[idx] = p_err;
                    f.b[idx] = p_blank;
                    exp_q.push_back(f);
                    p_frame = 1'b1;
                end
            end
        end
    end

    // Monitor: compares outputs against the model every cycle and pops the
    // scoreboard whenever the DUT strobes a frame.
    initial forever begin
        @(negedge clk);
        if (mon_on) begin
            chk("value", 32'(value), 32'(m_value));
            chk("err", 32'(err), 32'(m_err));
            chk("blank", 32'(blank), 32'(m_blank));
            chk("sel_err", 32'(sel_err), 32'(m_selerr));
            chk("frame_valid", 32'(fv), 32'(m_fv));
            if (fv) begin
                if (exp_q.size() == 0) begin
                    chk("frame_unexpected", 32'(1), 32'(0));
                end else begin
                    frame_t f;
                    f = exp_q.pop_front();
                    chk("frame_value", 32'(value), 32'(f.v));
                    chk("frame_err", 32'(err), 32'(f.e));
                    chk("frame_blank", 32'(blank), 32'(f.b));
                end
            end
        end
    end

    task automatic drive(input logic [6:0] s, input logic [3:0] l, input int n);
        repeat (n) begin
            @(negedge clk);
            seg = s;
            sel = l;
        end
    endtask

    task automatic show(input int d, input int g, input int n);
        logic [3:0] l;
        l = ~(4'b0001 << d);
        drive(glyph[g], l, n);
    endtask

    task automatic idle(input int n);
        drive(7'h7f, 4'hf, n);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b1;
        repeat (n - 1) @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        mon_on = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("reset_value", 32'(value), 32'h0);
        chk("reset_selerr", 32'(sel_err), 32'h0);

        // Basic scan 1,2,3,4
        for (int d = 0; d < 4; d++) show(d, d + 1, 4);
        idle(3);
        chk("scan_value", 32'(value), 32'h4321);
        chk("scan_err", 32'(err), 32'h0);

        // Too-short hold on digit 0 is not captured
        show(0, 8, 3);
        show(1, 5, 4);
        idle(3);
        chk("short_hold_d0", 32'(value[3:0]), 32'h1);

        // Blank and illegal glyphs
        show(0, 7, 4);
        show(1, 9, 4);
        drive(7'b1111111, 4'b1011, 4);
        drive(7'b1010101, 4'b0111, 4);
        idle(3);
        chk("blank_mask", 32'(blank), 32'h4);
        chk("err_mask", 32'(err), 32'h8);
        chk("hi_bytes", 32'(value[15:8]), 32'h0);

        // Two anodes at once
        drive(glyph[0], 4'b1100, 6);
        idle(2);
        chk("sel_err_set", 32'(sel_err), 32'h1);
        for (int d = 0; d < 4; d++) show(d, 10 + d, 4);
        idle(3);
        chk("sel_err_sticky", 32'(sel_err), 32'h1);

        // Reset mid-frame
        for (int d = 0; d < 3; d++) show(d, 6, 4);
        do_reset(1);
        show(3, 12, 4);
        idle(3);
        chk("post_reset_value", 32'(value), 32'hC000);
        chk("post_reset_selerr", 32'(sel_err), 32'h0);
        for (int d = 0; d < 3; d++) show(d, d + 13, 4);
        idle(3);

        // Long hold: single capture
        show(1, 15, 20);
        idle(3);
        chk("long_hold_d1", 32'(value[7:4]), 32'hF);

        // Random traffic
        for (int it = 0; it < 400; it++) begin
            int r;
            logic [6:0] s;
            logic [3:0] l;
            if ($urandom_range(0, 59) == 0) begin
                do_reset($urandom_range(1, 2));
            end else begin
                r = $urandom_range(0, 9);
                if (r < 8) l = ~(4'b0001 << $urandom_range(0, 3));
                else if (r == 8) l = 4'hf;
                else l = 4'($urandom_range(0, 15));
                r = $urandom_range(0, 9);
                if (r < 7) s = glyph[$urandom_range(0, 15)];
                else if (r == 7) s = 7'h7f;
                else s = 7'($urandom_range(0, 127));
                drive(s, l, $urandom_range(1, 8));
            end
        end
        idle(4);
        chk("frames_left", 32'(exp_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
